// File: rtl/data_memory_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pipelined
// Description : Byte-addressed little-endian data memory with one-cycle
//               registered responses, signed/unsigned sub-word loads, range
//               and encoding fault detection, and a sticky fault record.
//               Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half
//               and word accesses into faults; otherwise they are served
//               byte-wise.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_pipelined #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  input  logic [2:0]        DMCtrl,
  input  logic              DMWr,
  input  logic              FaultClr,
  output logic              RspValid,
  output logic [31:0]       DataRd,
  output logic              RspFault,
  output logic              FaultSticky,
  output logic [ADDR_W-1:0] FaultAddr
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [7:0]          r_mem [0:DEPTH-1];

  logic [1:0]          w_len_m1;     // access length in bytes, minus one
  logic [3:0]          w_be;         // byte lanes touched by a store
  logic                w_size_ok;
  logic [ADDR_W:0]     w_last;       // address of the last byte, one bit wider
  logic                w_range_fault;
  logic                w_kind_fault;
  logic                w_misalign;
  logic                w_fault;
  logic                w_commit;
  logic [c_idx_w-1:0]  w_base;
  logic [c_idx_w-1:0]  w_idx [4];
  logic [7:0]          w_byte [4];
  logic [31:0]         w_load;

  // Decode the access size and the store byte-enable pattern from DMCtrl
  always_comb begin
    w_len_m1  = 2'd0;
    w_be      = 4'b0000;
    w_size_ok = 1'b1;
    case (DMCtrl)
      3'b000, 3'b100: begin w_len_m1 = 2'd0; w_be = 4'b0001; end
      3'b001, 3'b101: begin w_len_m1 = 2'd1; w_be = 4'b0011; end
      3'b010:         begin w_len_m1 = 2'd3; w_be = 4'b1111; end
      default:        w_size_ok = 1'b0;
    endcase
  end

  // The wider sum keeps addresses near the top of the address space from
  // wrapping back into range
  assign w_last        = {1'b0, Address} + {{(ADDR_W-1){1'b0}}, w_len_m1};
  assign w_range_fault = (w_last >= c_depth);
  assign w_kind_fault  = !w_size_ok || (DMWr && DMCtrl[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_len_m1 == 2'd1) && Address[0]) ||
                      ((w_len_m1 == 2'd3) && (Address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault  = w_range_fault || w_kind_fault || w_misalign;
  assign w_commit = Req && DMWr && !w_fault;
  assign w_base   = Address[c_idx_w-1:0];

  // Per-lane byte index; wrapping only happens on faulted accesses whose
  // data is discarded
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_idx[gi]  = w_base + c_idx_w'(gi);
    assign w_byte[gi] = r_mem[w_idx[gi]];
  end

  // Assemble the load value with sign or zero extension
  always_comb begin
    w_load = 32'd0;
    case (DMCtrl)
      3'b000: w_load = {{24{w_byte[0][7]}}, w_byte[0]};
      3'b001: w_load = {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
      3'b010: w_load = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
      3'b100: w_load = {24'd0, w_byte[0]};
      3'b101: w_load = {16'd0, w_byte[1], w_byte[0]};
      default: w_load = 32'd0;
    endcase
  end

  // Store commit on the acceptance edge; memory contents survive reset
  always_ff @(posedge Clk) begin
    if (w_commit) begin
      if (w_be[0]) r_mem[w_idx[0]] <= DataWr[7:0];
      if (w_be[1]) r_mem[w_idx[1]] <= DataWr[15:8];
      if (w_be[2]) r_mem[w_idx[2]] <= DataWr[23:16];
      if (w_be[3]) r_mem[w_idx[3]] <= DataWr[31:24];
    end
  end

  // Registered response: one cycle after acceptance, data held when idle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RspValid <= 1'b0;
      RspFault <= 1'b0;
      DataRd   <= 32'd0;
    end else begin
      RspValid <= Req;
      if (Req) begin
        RspFault <= w_fault;
        DataRd   <= (w_fault || DMWr) ? 32'd0 : w_load;
      end
    end
  end

  // Sticky fault record; a new fault outranks a simultaneous clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      FaultSticky <= 1'b0;
      FaultAddr   <= '0;
    end else if (Req && w_fault) begin
      FaultSticky <= 1'b1;
      if (!FaultSticky || FaultClr) begin
        FaultAddr <= Address;
      end
    end else if (FaultClr) begin
      FaultSticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_pipelined
// Description : Self-checking bench for data_memory_pipelined. Responses are
//               compared against a byte-array reference model of the memory
//               and the sticky fault record.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_pipelined;

  localparam int DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic [2:0]  DMCtrl;
  logic        DMWr;
  logic        FaultClr;
  logic        RspValid;
  logic [31:0] DataRd;
  logic        RspFault;
  logic        FaultSticky;
  logic [31:0] FaultAddr;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  mdl_mem [DEPTH];
  logic        m_sticky;
  logic [31:0] m_faddr;
  logic [31:0] m_last;
  logic        ex_fault;
  logic [31:0] ex_data;

  data_memory_pipelined #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Address(Address), .DataWr(DataWr),
    .DMCtrl(DMCtrl), .DMWr(DMWr), .FaultClr(FaultClr), .RspValid(RspValid),
    .DataRd(DataRd), .RspFault(RspFault), .FaultSticky(FaultSticky),
    .FaultAddr(FaultAddr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: apply one request at the architectural level
  task automatic model(input bit wr, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] data, input bit clr);
    int n;
    bit sgn;
    n = 0;
    sgn = 0;
    case (ctrl)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    ex_fault = (n == 0) || (wr && (ctrl == 3'd4 || ctrl == 3'd5)) ||
               (longint'(addr) + longint'(n) > longint'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (n == 2 && (addr % 2) != 0) ex_fault = 1'b1;
    if (n == 4 && (addr % 4) != 0) ex_fault = 1'b1;
`endif
    ex_data = 32'd0;
    if (!ex_fault) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mdl_mem[addr + i] = data[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) ex_data = ex_data | (32'(mdl_mem[addr + i]) << (8*i));
        if (sgn && ex_data[8*n-1]) ex_data = ex_data | ~((32'd1 << (8*n)) - 32'd1);
      end
    end
    if (ex_fault) begin
      if (!m_sticky || clr) m_faddr = addr;
      m_sticky = 1'b1;
    end else if (clr) begin
      m_sticky = 1'b0;
    end
    m_last = ex_data;
  endtask

  // Drive one request at a falling edge; returns at the next falling edge
  // with the response on the outputs
  task automatic req(input bit wr, input logic [2:0] ctrl, input logic [31:0] addr,
                     input logic [31:0] data, input bit clr);
    Address  = addr;
    DMWr     = wr;
    DMCtrl   = ctrl;
    DataWr   = data;
    FaultClr = clr;
    Req      = 1'b1;
    model(wr, ctrl, addr, data, clr);
    @(negedge Clk);
    Req      = 1'b0;
    FaultClr = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Req = 1'b0; DMWr = 1'b0; FaultClr = 1'b0;
    Address = '0; DataWr = '0; DMCtrl = '0;
    m_sticky = 1'b0; m_faddr = '0; m_last = '0;
    repeat (2) @(negedge Clk);
    total++; if (RspValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", RspValid); end
    total++; if (RspFault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b expected 0", RspFault); end
    total++; if (DataRd !== 32'd0) begin bad++; $display("FAIL reset_data: got %h expected 0", DataRd); end
    total++; if (FaultSticky !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b expected 0", FaultSticky); end
    total++; if (FaultAddr !== 32'd0) begin bad++; $display("FAIL reset_faddr: got %h expected 0", FaultAddr); end
    Rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEPTH; a += 4) begin
      req(1'b1, 3'b010, 32'(a), $urandom, 1'b0);
      total++;
      if ({RspValid, RspFault, DataRd} !== {1'b1, 1'b0, 32'd0}) begin
        bad++;
        $display("FAIL fill_store @%h: got v=%b f=%b d=%h expected v=1 f=0 d=0", a, RspValid, RspFault, DataRd);
      end
    end
  endtask

  task automatic test_store_load();
    logic [2:0]  ctl [5]  = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b001};
    logic [31:0] adr [5]  = '{32'h10, 32'h13, 32'h13, 32'h13, 32'h12};
    logic [31:0] want [5] = '{32'h11223344, 32'h00000011, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8022};
    req(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req(1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0);
      req(1'b0, ctl[i], adr[i], 32'd0, 1'b0);
      total++;
      if ({RspValid, RspFault, DataRd} !== {1'b1, 1'b0, want[i]} || ex_data !== want[i]) begin
        bad++;
        $display("FAIL load_%0d ctrl=%b @%h: got v=%b f=%b d=%h expected v=1 f=0 d=%h",
                 i, ctl[i], adr[i], RspValid, RspFault, DataRd, want[i]);
      end
    end
  endtask

  task automatic test_faults();
    req(1'b0, 3'b010, 32'h3FE, 32'd0, 1'b0);
    total++;
    if ({RspValid, RspFault, DataRd, FaultSticky, FaultAddr} !== {1'b1, 1'b1, 32'd0, 1'b1, 32'h3FE}) begin
      bad++;
      $display("FAIL range_fault: got v=%b f=%b d=%h s=%b a=%h expected v=1 f=1 d=0 s=1 a=3fe",
               RspValid, RspFault, DataRd, FaultSticky, FaultAddr);
    end
    req(1'b0, 3'b100, 32'h500, 32'd0, 1'b0);
    total++;
    if ({RspFault, FaultSticky, FaultAddr} !== {1'b1, 1'b1, 32'h3FE}) begin
      bad++;
      $display("FAIL second_fault: got f=%b s=%b a=%h expected f=1 s=1 a=3fe", RspFault, FaultSticky, FaultAddr);
    end
    req(1'b1, 3'b100, 32'h20, 32'h000000A5, 1'b0);
    total++;
    if ({RspFault, DataRd} !== {1'b1, 32'd0}) begin
      bad++;
      $display("FAIL unsigned_store_fault: got f=%b d=%h expected f=1 d=0", RspFault, DataRd);
    end
    req(1'b0, 3'b010, 32'h20, 32'd0, 1'b0);
    total++;
    if ({RspFault, DataRd} !== {1'b0, ex_data}) begin
      bad++;
      $display("FAIL mem_unchanged @20: got f=%b d=%h expected f=0 d=%h", RspFault, DataRd, ex_data);
    end
    req(1'b1, 3'b101, 32'h24, 32'h1234, 1'b1);
    total++;
    if ({RspFault, FaultSticky, FaultAddr} !== {1'b1, 1'b1, 32'h24}) begin
      bad++;
      $display("FAIL clr_vs_fault: got f=%b s=%b a=%h expected f=1 s=1 a=24", RspFault, FaultSticky, FaultAddr);
    end
    req(1'b0, 3'b010, 32'h0, 32'd0, 1'b1);
    total++;
    if ({RspFault, FaultSticky} !== {1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fault_clear: got f=%b s=%b expected f=0 s=0", RspFault, FaultSticky);
    end
  endtask

  task automatic test_boundary();
    logic [2:0]  ctl [7] = '{3'b100, 3'b101, 3'b010, 3'b001, 3'b011, 3'b110, 3'b111};
    logic [31:0] adr [7] = '{32'h3FF, 32'h3FF, 32'h3FC, 32'h3FE, 32'h0, 32'h4, 32'h8};
    bit          flt [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      req(1'b0, ctl[i], adr[i], 32'd0, 1'b1);
      total++;
      if ({RspValid, RspFault, DataRd, FaultSticky, FaultAddr} !== {1'b1, flt[i], ex_data, m_sticky, m_faddr}
          || ex_fault !== flt[i]) begin
        bad++;
        $display("FAIL boundary_%0d ctrl=%b @%h: got f=%b d=%h s=%b a=%h expected f=%b d=%h s=%b a=%h",
                 i, ctl[i], adr[i], RspFault, DataRd, FaultSticky, FaultAddr, flt[i], ex_data, m_sticky, m_faddr);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_d;
    req(1'b0, 3'b010, 32'h11, 32'd0, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_d = 32'd0;
    total++;
    if ({RspFault, DataRd} !== {1'b1, exp_d}) begin
      bad++;
      $display("FAIL misalign_word: got f=%b d=%h expected f=1 d=0", RspFault, DataRd);
    end
`else
    exp_d = {mdl_mem[32'h14], mdl_mem[32'h13], mdl_mem[32'h12], mdl_mem[32'h11]};
    total++;
    if ({RspFault, DataRd} !== {1'b0, exp_d}) begin
      bad++;
      $display("FAIL misalign_word: got f=%b d=%h expected f=0 d=%h", RspFault, DataRd, exp_d);
    end
`endif
    req(1'b0, 3'b001, 32'h21, 32'd0, 1'b0);
    total++;
    if ({RspFault, DataRd} !== {ex_fault, ex_data}) begin
      bad++;
      $display("FAIL misalign_half: got f=%b d=%h expected f=%b d=%h", RspFault, DataRd, ex_fault, ex_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  c;
    bit          w;
    bit          clr;
    int          r;
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        Req = 1'b0;
        @(negedge Clk);
        total++;
        if ({RspValid, DataRd} !== {1'b0, m_last}) begin
          bad++;
          $display("FAIL idle_hold it=%0d: got v=%b d=%h expected v=0 d=%h", it, RspValid, DataRd, m_last);
        end
      end
      r = $urandom_range(0, 19);
      if (r == 0)      a = $urandom;
      else if (r < 3)  a = 32'(DEPTH - 4 + $urandom_range(0, 7));
      else             a = 32'($urandom_range(0, DEPTH - 1));
      c   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'({$urandom_range(0, 1), 2'($urandom_range(0, 2))});
      w   = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 7) == 0);
      req(w, c, a, $urandom, clr);
      total++;
      if ({RspValid, RspFault, DataRd, FaultSticky, FaultAddr} !== {1'b1, ex_fault, ex_data, m_sticky, m_faddr}) begin
        bad++;
        $display("FAIL random_%0d wr=%b ctrl=%b @%h: got v=%b f=%b d=%h s=%b a=%h expected f=%b d=%h s=%b a=%h",
                 it, w, c, a, RspValid, RspFault, DataRd, FaultSticky, FaultAddr, ex_fault, ex_data, m_sticky, m_faddr);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) req(1'b0, 3'b010, 32'(4 * i), 32'd0, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({RspValid, RspFault, DataRd, FaultSticky, FaultAddr} !== 66'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b f=%b d=%h s=%b a=%h expected all 0",
               RspValid, RspFault, DataRd, FaultSticky, FaultAddr);
    end
    Address = 32'h40; DMCtrl = 3'b010; DMWr = 1'b0; Req = 1'b1;
    @(negedge Clk);
    Req = 1'b0;
    total++;
    if ({RspValid, DataRd} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL req_in_reset: got v=%b d=%h expected v=0 d=0", RspValid, DataRd);
    end
    Rst_n = 1'b1;
    m_sticky = 1'b0; m_faddr = '0; m_last = '0;
    @(negedge Clk);
    total++;
    if ({RspValid, DataRd, FaultSticky} !== {1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_idle: got v=%b d=%h s=%b expected 0", RspValid, DataRd, FaultSticky);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
      req(1'b0, 3'b010, a, 32'd0, 1'b0);
      total++;
      if ({RspValid, RspFault, DataRd} !== {1'b1, 1'b0, ex_data}) begin
        bad++;
        $display("FAIL mem_intact @%h: got v=%b f=%b d=%h expected v=1 f=0 d=%h", a, RspValid, RspFault, DataRd, ex_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_faults();
    test_boundary();
    test_misalign();
    test_random();
    test_back_to_back_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_pipelined.md
DATA_MEMORY_PIPELINED -- requirements
Module: data_memory_pipelined

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the memory size in bytes; it SHALL be a power of two and at least 4.
REQ-002 Parameter ADDR_W, default 32, SHALL set the width of Address.
REQ-003 Clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Req  in  1  SHALL flag a valid request; it is accepted on any rising edge where Req=1.
REQ-006 Address  in  ADDR_W  SHALL be the byte address of the request.
REQ-007 DataWr  in  32  SHALL carry store data, right-aligned.
REQ-008 DMCtrl  in  3  SHALL select the access type: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 DMWr  in  1  SHALL select store (1) or load (0).
REQ-010 FaultClr  in  1  SHALL clear the sticky fault state.
REQ-011 RspValid  out  1  SHALL pulse for one cycle per accepted request.
REQ-012 DataRd  out  32  SHALL carry load data, qualified by RspValid.
REQ-013 RspFault  out  1  SHALL flag a faulted request, qualified by RspValid.
REQ-014 FaultSticky  out  1  SHALL hold the sticky fault flag.
REQ-015 FaultAddr  out  ADDR_W  SHALL hold the address of the first unacknowledged fault.

Function
REQ-016 The block SHALL accept one request per cycle with no backpressure; the response SHALL appear exactly 1 cycle after acceptance.
REQ-017 Byte order SHALL be little-endian for every size: byte at Address maps to bits 7:0, Address+1 to bits 15:8, and so on.
REQ-018 Signed loads SHALL sign-extend from bit 7 or 15; unsigned loads and word loads SHALL zero-fill unused bits.
REQ-019 Stores SHALL commit on the acceptance edge; sizes are byte for 000, half for 001 and word for 010.
REQ-020 A load accepted the cycle after a store to the same bytes SHALL return the new data.
REQ-021 Store responses SHALL drive DataRd=0.
REQ-022 Access classification:
- Fault when the access's last byte is at or above DEPTH.
- Fault when DMCtrl is 011, 110 or 111.
- Fault for a store with DMCtrl 100 or 101.
REQ-023 A faulted request SHALL not modify memory, SHALL drive DataRd=0 and SHALL drive RspFault=1.
REQ-024 On a fault, FaultSticky SHALL set; FaultAddr SHALL capture Address only if FaultSticky was 0.
REQ-025 If FaultClr and a new fault coincide, the new fault SHALL win: FaultSticky=1 and FaultAddr=new Address.
REQ-026 When Req=0, RspValid SHALL be 0 in the following cycle and DataRd SHALL hold its last value.

Reset
REQ-027 While Rst_n=0, outputs SHALL be forced to: RspValid=0, RspFault=0, DataRd=0, FaultSticky=0, FaultAddr=0.
REQ-028 Memory contents SHALL not be reset.
REQ-029 A request accepted in the cycle reset asserts SHALL produce no response; a store in that cycle MAY be lost.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a half access with Address[0]=1 or a word access with Address[1:0]!=0 SHALL fault per REQ-023/024.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, misaligned accesses SHALL complete byte-wise little-endian; only the range and encoding faults of REQ-022 apply.

Verification
REQ-032 Store word 0x11223344 @0x10, load word @0x10 next cycle -> RspValid 1 cycle later, DataRd=0x11223344.
REQ-033 After REQ-032:
- byte signed @0x13 -> DataRd=0x00000011.
- store byte 0x80 @0x13, then byte signed @0x13 -> 0xFFFFFF80; byte unsigned @0x13 -> 0x00000080.
- half signed @0x12 -> 0xFFFF8022.
REQ-034 With DEPTH=1024, load word @0x3FE -> RspFault=1, DataRd=0, FaultSticky=1, FaultAddr=0x3FE; a second fault @0x500 SHALL leave FaultAddr at 0x3FE.
REQ-035 Store with DMCtrl=100 @0x20 -> RspFault=1 and memory @0x20 unchanged; asserting FaultClr in the same cycle as a new fault @0x24 -> FaultSticky=1, FaultAddr=0x24.
REQ-036 Load word @0x11:
- macro defined -> RspFault=1, DataRd=0.
- macro undefined -> RspFault=0, DataRd = bytes 0x11..0x14 little-endian.
REQ-037 Assert Rst_n=0 mid-stream of back-to-back loads -> all outputs 0 immediately; after release, memory contents SHALL still be intact.
